// File: rtl/topk_pkg.sv
//------------------------------------------------------------------------------
// Package : topk_pkg
// Purpose : Shared types and helpers for the top-k stream reader at the end
//           of the sorter datapath.
//           - state_e   : reader FSM states
//           - MAX_DATALENGTH / LENW : default vector size and length width
//           - clamp_len : min() helper used for length and k clamping
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package topk_pkg;

  localparam int MAX_DATALENGTH = 32;
  localparam int LENW           = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Saturating clamp: returns min(len, max).
  function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len,
                                                input logic [LENW-1:0] max);
    return (len > max) ? max : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/topk_stream_out.sv
//------------------------------------------------------------------------------
// Module  : topk_stream_out
// Purpose : Captures one ascending-sorted, padded vector plus its real length
//           and streams the k largest real entries out, largest first, one
//           per beat over a valid/ready interface. Padding entries (above the
//           real length) are skipped purely by position.
//
// Ports   : clk_i            clock, rising edge
//           rstn_i           asynchronous active-low reset
//           in_valid_i       input vector valid
//           in_ready_o       block idle and able to accept a vector
//           sorted_i         DATAWIDTH x MAX_DATALENGTH, entry i at
//                            [i*DATAWIDTH +: DATAWIDTH], ascending
//           in_data_length_i unpadded length
//           k_i              number of top entries wanted
//           m_valid_o        output beat valid
//           m_ready_i        downstream ready
//           m_data_o         element value
//           m_rank_o         0 for the largest element, then 1, 2, ...
//           m_last_o         final beat of this vector
//           done_o           one-cycle pulse after the vector is emitted
//           abort_i          (TOPK_ABORT_EN only) drop the current vector
//
// Config  : define TOPK_ABORT_EN to add abort_i.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module topk_stream_out #(
  parameter int DATAWIDTH      = 8,
  parameter int MAX_DATALENGTH = 32,
  parameter int LENW           = 6
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATAWIDTH*MAX_DATALENGTH-1:0] sorted_i,
  input  logic [LENW-1:0]                     in_data_length_i,
  input  logic [LENW-1:0]                     k_i,
`ifdef TOPK_ABORT_EN
  input  logic                                abort_i,
`endif
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic [DATAWIDTH-1:0]                m_data_o,
  output logic [LENW-1:0]                     m_rank_o,
  output logic                                m_last_o,
  output logic                                done_o
);

  import topk_pkg::*;

  localparam int PTRW = (MAX_DATALENGTH > 1) ? $clog2(MAX_DATALENGTH) : 1;

  state_e                 state;
  state_e                 state_nxt;
  logic [DATAWIDTH-1:0]   buffer [MAX_DATALENGTH];
  logic [PTRW-1:0]        ptr;
  logic [LENW-1:0]        cnt;
  logic [LENW-1:0]        k_eff_q;

  logic [LENW-1:0]        len_eff;
  logic [LENW-1:0]        k_eff;
  logic [LENW-1:0]        len_m1;
  logic                   accept;
  logic                   handshake;
  logic                   is_last;

  // Clamp length to the buffer size, then k to the real length, so the
  // read pointer can never walk below entry 0.
  assign len_eff   = clamp_len(in_data_length_i, LENW'(MAX_DATALENGTH));
  assign k_eff     = clamp_len(k_i, len_eff);
  assign len_m1    = len_eff - LENW'(1);

  assign accept    = in_valid_i && (state == IDLE);
  assign handshake = (state == STREAM) && m_ready_i;
  assign is_last   = (cnt == (k_eff_q - LENW'(1)));

  //----------------------------------------------------------------------------
  // FSM: state register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // FSM: next-state logic
  //----------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (k_eff == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (handshake && is_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef TOPK_ABORT_EN
    // Abort wins over a simultaneous handshake and suppresses done_o.
    if (abort_i && (state != IDLE)) begin
      state_nxt = IDLE;
    end
`endif
  end

  //----------------------------------------------------------------------------
  // FSM: outputs
  //----------------------------------------------------------------------------
  always_comb begin
    in_ready_o = 1'b0;
    m_valid_o  = 1'b0;
    m_data_o   = '0;
    m_rank_o   = '0;
    m_last_o   = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
      end
      STREAM: begin
        m_valid_o = 1'b1;
        m_data_o  = buffer[ptr];
        m_rank_o  = cnt;
        m_last_o  = is_last;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Datapath: buffer, read pointer, beat counter, registered k
  //----------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < MAX_DATALENGTH; i++) begin
        buffer[i] <= '0;
      end
      ptr     <= '0;
      cnt     <= '0;
      k_eff_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < MAX_DATALENGTH; i++) begin
        buffer[i] <= sorted_i[i*DATAWIDTH +: DATAWIDTH];
      end
      // Top real entry sits at len_eff-1; when len_eff is 0 the pointer
      // value is irrelevant because no beat is emitted.
      ptr     <= len_m1[PTRW-1:0];
      cnt     <= '0;
      k_eff_q <= k_eff;
    end else if (handshake) begin
      ptr <= ptr - PTRW'(1);
      cnt <= cnt + LENW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_topk_stream_out.sv
`default_nettype none

module tb_topk_stream_out;

  localparam int DW  = 8;
  localparam int ML  = 32;
  localparam int LW  = 6;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [DW*ML-1:0] sorted_i;
  logic [LW-1:0]    in_data_length_i;
  logic [LW-1:0]    k_i;
`ifdef TOPK_ABORT_EN
  logic             abort_i;
`endif
  logic             m_valid_o;
  logic             m_ready_i;
  logic [DW-1:0]    m_data_o;
  logic [LW-1:0]    m_rank_o;
  logic             m_last_o;
  logic             done_o;

  int errors = 0;
  int checks = 0;

  topk_stream_out #(
    .DATAWIDTH      (DW),
    .MAX_DATALENGTH (ML),
    .LENW           (LW)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .sorted_i         (sorted_i),
    .in_data_length_i (in_data_length_i),
    .k_i              (k_i),
`ifdef TOPK_ABORT_EN
    .abort_i          (abort_i),
`endif
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .m_data_o         (m_data_o),
    .m_rank_o         (m_rank_o),
    .m_last_o         (m_last_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_pad(input logic [DW-1:0] pad);
    for (int i = 0; i < ML; i++) sorted_i[i*DW +: DW] = pad;
  endtask

  task automatic set_entry(input int idx, input logic [DW-1:0] val);
    sorted_i[idx*DW +: DW] = val;
  endtask

  // Present a vector for one edge; DUT must be in IDLE.
  task automatic send(input logic [LW-1:0] len, input logic [LW-1:0] k);
    in_data_length_i = len;
    k_i              = k;
    in_valid_i       = 1'b1;
    tick();
    in_valid_i       = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [DW-1:0] d,
                             input logic [LW-1:0] r, input logic l);
    check({tag, ".valid"}, {31'd0, m_valid_o}, 32'd1);
    check({tag, ".data"},  {24'd0, m_data_o}, {24'd0, d});
    check({tag, ".rank"},  {26'd0, m_rank_o}, {26'd0, r});
    check({tag, ".last"},  {31'd0, m_last_o}, {31'd0, l});
  endtask

  task automatic expect_done(input string tag);
    check({tag, ".done"},     {31'd0, done_o},     32'd1);
    check({tag, ".dvalid"},   {31'd0, m_valid_o},  32'd0);
    check({tag, ".dready"},   {31'd0, in_ready_o}, 32'd0);
    tick();
    check({tag, ".done_end"}, {31'd0, done_o},     32'd0);
    check({tag, ".idle"},     {31'd0, in_ready_o}, 32'd1);
  endtask

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] t4_data [6];
    logic [LW-1:0] t4_rank [6];
    logic          t4_last [6];
    logic          t4_rdy  [6];

    rstn_i = 1'b0; in_valid_i = 1'b0; m_ready_i = 1'b1;
    sorted_i = '0; in_data_length_i = '0; k_i = '0;
`ifdef TOPK_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.ready", {31'd0, in_ready_o}, 32'd1);
    check("rst.valid", {31'd0, m_valid_o},  32'd0);
    check("rst.done",  {31'd0, done_o},     32'd0);
    check("rst.data",  {24'd0, m_data_o},   32'd0);
    check("rst.rank",  {26'd0, m_rank_o},   32'd0);
    check("rst.last",  {31'd0, m_last_o},   32'd0);
    rstn_i = 1'b1;
    tick();

    // 1: len 5, k 3, padding 127 must never appear
    fill_pad(8'd127);
    set_entry(0, 8'd3); set_entry(1, 8'd9); set_entry(2, 8'd12);
    set_entry(3, 8'd40); set_entry(4, 8'd77);
    send(6'd5, 6'd3);
    expect_beat("t1b0", 8'd77, 6'd0, 1'b0); tick();
    expect_beat("t1b1", 8'd40, 6'd1, 1'b0); tick();
    expect_beat("t1b2", 8'd12, 6'd2, 1'b1); tick();
    expect_done("t1");

    // 2: k larger than len -> only len beats
    fill_pad(8'd99);
    for (int i = 0; i < 4; i++) set_entry(i, DW'(i + 1));
    send(6'd4, 6'd10);
    for (int i = 0; i < 4; i++) begin
      expect_beat($sformatf("t2b%0d", i), DW'(4 - i), LW'(i), i == 3);
      tick();
    end
    expect_done("t2");

    // 3: k = 0 -> no beats, done right after acceptance
    send(6'd8, 6'd0);
    expect_done("t3");

    // 4: back-pressure; outputs hold while stalled
    fill_pad(8'd120);
    set_entry(0, 8'd5); set_entry(1, 8'd6); set_entry(2, 8'd7);
    t4_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    t4_data = '{8'd7, 8'd6, 8'd6, 8'd6, 8'd5, 8'd5};
    t4_rank = '{6'd0, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2};
    t4_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    send(6'd3, 6'd3);
    for (int i = 0; i < 6; i++) begin
      m_ready_i = t4_rdy[i];
      expect_beat($sformatf("t4c%0d", i), t4_data[i], t4_rank[i], t4_last[i]);
      tick();
    end
    m_ready_i = 1'b1;
    expect_done("t4");

    // 5: length 40 clamps to 32; mid-stream vector ignored
    for (int i = 0; i < ML; i++) set_entry(i, DW'(i));
    send(6'd40, 6'd2);
    expect_beat("t5b0", 8'd31, 6'd0, 1'b0);
    fill_pad(8'd200);
    in_data_length_i = 6'd5; k_i = 6'd5; in_valid_i = 1'b1;
    tick();
    expect_beat("t5b1", 8'd30, 6'd1, 1'b1);
    tick();
    in_valid_i = 1'b0;
    expect_done("t5");
    check("t5.novalid", {31'd0, m_valid_o}, 32'd0);

    // 6: reset during beat 2
    for (int i = 0; i < 6; i++) set_entry(i, DW'(10 + i));
    send(6'd6, 6'd6);
    expect_beat("t6b0", 8'd15, 6'd0, 1'b0); tick();
    expect_beat("t6b1", 8'd14, 6'd1, 1'b0);
    rstn_i = 1'b0;
    #1;
    check("t6.valid", {31'd0, m_valid_o}, 32'd0);
    check("t6.data",  {24'd0, m_data_o},  32'd0);
    check("t6.rank",  {26'd0, m_rank_o},  32'd0);
    check("t6.last",  {31'd0, m_last_o},  32'd0);
    check("t6.done",  {31'd0, done_o},    32'd0);
    #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6.nodone%0d", i), {31'd0, done_o},     32'd0);
      check($sformatf("t6.ready%0d", i),  {31'd0, in_ready_o}, 32'd1);
    end

`ifdef TOPK_ABORT_EN
    // 6b: abort during beat 2 behaves like the reset case
    send(6'd6, 6'd6);
    expect_beat("t6ab0", 8'd15, 6'd0, 1'b0); tick();
    expect_beat("t6ab1", 8'd14, 6'd1, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t6a.valid", {31'd0, m_valid_o},  32'd0);
    check("t6a.done",  {31'd0, done_o},     32'd0);
    check("t6a.ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    check("t6a.nodone", {31'd0, done_o}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
